divsqrt_prenorm: RTL and testbench

- Input-side counterpart of the divsqrt result shift-calculation logic. It normalizes the X and Y significands before the divsqrt iteration and produces the biased pre-result exponent DivUe (NE+2 bits, two's complement) that the output shift calculation later consumes.
- Handles subnormal operands with a leading-zero count followed by a left shift.
- Multi-cycle FSM with valid/ready handshakes on both sides.
- Sits between the FPU operand unpacker and the divsqrt iteration unit.

---
 rtl/divsqrt_prenorm_pkg.sv | 20 ++
 rtl/prenorm_lzc.sv | 18 +
 rtl/divsqrt_prenorm.sv | 142 ++++++++++++++
 tb/tb_divsqrt_prenorm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/divsqrt_prenorm_pkg.sv
// rtl/divsqrt_prenorm_pkg.sv - shared state encoding and width constants for the divsqrt operand pre-normalizer
package divsqrt_prenorm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LZC   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NE_DEF   = 11;
    localparam int NF_DEF   = 52;
    localparam int BIAS_DEF = 1023;

    // Count width must hold NF+1, the count of an all-zero significand
    localparam int LZW = $clog2(NF_DEF + 2);

    localparam logic [NE_DEF+1:0] BIAS_E = (NE_DEF + 2)'(BIAS_DEF);

endpackage

// File: rtl/prenorm_lzc.sv
// rtl/prenorm_lzc.sv - combinational leading-zero counter, all-zero input counts as W
module prenorm_lzc #(
    parameter int W  = 53,
    parameter int CW = 6
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/divsqrt_prenorm.sv
// rtl/divsqrt_prenorm.sv - normalizes divsqrt operands and forms the biased pre-result exponent
// Optional macro DIVSQRT_PRENORM_FASTPATH_EN lets normal operands skip the LZC state.
module divsqrt_prenorm
    import divsqrt_prenorm_pkg::*;
#(
    parameter int NE   = NE_DEF,
    parameter int NF   = NF_DEF,
    parameter int BIAS = BIAS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic          Abort,
    input  logic          SqrtE,
    input  logic [NE-1:0] XeE,
    input  logic [NE-1:0] YeE,
    input  logic [NF:0]   XmE,
    input  logic [NF:0]   YmE,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [NF:0]   Xnorm,
    output logic [NF:0]   Dnorm,
    output logic [NE+1:0] DivUe,
    output logic          SqrtOdd,
    output logic          ZeroIn
);

    localparam int EW    = NE + 2;
    localparam int LZW_L = $clog2(NF + 2);
    localparam logic [EW-1:0] BIAS_W = EW'(BIAS);

    state_t state, stateNext;

    logic             sqrtR;
    logic [NE-1:0]    xeR, yeR;
    logic [NF:0]      xmR, ymR;
    logic [LZW_L-1:0] lzX, lzY, lzXc, lzYc;

    logic accept, fastOk;

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign accept   = InReady && InValid && !Abort;

`ifdef DIVSQRT_PRENORM_FASTPATH_EN
    assign fastOk = (XeE != '0) && (SqrtE || (YeE != '0));
`else
    assign fastOk = 1'b0;
`endif

    prenorm_lzc #(.W(NF + 1), .CW(LZW_L)) uLzcX (.value(xmR), .count(lzXc));
    prenorm_lzc #(.W(NF + 1), .CW(LZW_L)) uLzcY (.value(ymR), .count(lzYc));

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (accept) stateNext = fastOk ? SHIFT : LZC;
            LZC:   stateNext = SHIFT;
            SHIFT: stateNext = DONE;
            DONE:  if (OutReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (Abort && state != IDLE) stateNext = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sqrtR <= 1'b0;
            xeR   <= '0;
            yeR   <= '0;
            xmR   <= '0;
            ymR   <= '0;
            lzX   <= '0;
            lzY   <= '0;
        end else begin
            if (accept) begin
                sqrtR <= SqrtE;
                xeR   <= XeE;
                yeR   <= YeE;
                xmR   <= XmE;
                ymR   <= YmE;
                lzX   <= '0;
                lzY   <= '0;
            end else if (state == LZC) begin
                lzX <= lzXc;
                lzY <= lzYc;
            end
        end
    end

    // Exponent arithmetic in NE+2 bit two's complement; subnormals use exponent 1
    logic [EW-1:0] xEff, yEff, u, uHalf, divUeC;
    logic [NF:0]   xnormC, dnormC;
    logic          zeroC, sqrtOddC;

    always_comb begin
        xEff     = ((xeR == '0) ? EW'(1) : EW'(xeR)) - EW'(lzX);
        yEff     = ((yeR == '0) ? EW'(1) : EW'(yeR)) - EW'(lzY);
        u        = xEff - BIAS_W;
        uHalf    = {u[EW-1], u[EW-1:1]};
        xnormC   = xmR << lzX;
        dnormC   = ymR << lzY;
        zeroC    = (xmR == '0) || (!sqrtR && (ymR == '0));
        sqrtOddC = 1'b0;
        if (sqrtR) begin
            divUeC   = uHalf + BIAS_W;
            sqrtOddC = u[0];
            dnormC   = '0;
        end else begin
            divUeC = xEff - yEff + BIAS_W;
        end
        if (zeroC) begin
            xnormC   = '0;
            dnormC   = '0;
            divUeC   = '0;
            sqrtOddC = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Xnorm   <= '0;
            Dnorm   <= '0;
            DivUe   <= '0;
            SqrtOdd <= 1'b0;
            ZeroIn  <= 1'b0;
        end else if (state == SHIFT && !Abort) begin
            Xnorm   <= xnormC;
            Dnorm   <= dnormC;
            DivUe   <= divUeC;
            SqrtOdd <= sqrtOddC;
            ZeroIn  <= zeroC;
        end
    end

endmodule

// File: tb/tb_divsqrt_prenorm.sv
// tb/tb_divsqrt_prenorm.sv - directed self-checking bench for divsqrt_prenorm
module tb_divsqrt_prenorm;
    import divsqrt_prenorm_pkg::*;

    localparam logic [52:0] ONE = 53'd1 << 52;
`ifdef DIVSQRT_PRENORM_FASTPATH_EN
    localparam int NORM_LAT = 1;
`else
    localparam int NORM_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        Abort = 1'b0;
    logic        SqrtE = 1'b0;
    logic [10:0] XeE = '0;
    logic [10:0] YeE = '0;
    logic [52:0] XmE = '0;
    logic [52:0] YmE = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [52:0] Xnorm;
    logic [52:0] Dnorm;
    logic [12:0] DivUe;
    logic        SqrtOdd;
    logic        ZeroIn;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    divsqrt_prenorm dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .Abort(Abort),
        .SqrtE(SqrtE), .XeE(XeE), .YeE(YeE), .XmE(XmE), .YmE(YmE),
        .OutValid(OutValid), .OutReady(OutReady), .Xnorm(Xnorm), .Dnorm(Dnorm),
        .DivUe(DivUe), .SqrtOdd(SqrtOdd), .ZeroIn(ZeroIn)
    );

    // Issue one operation and return cycles from the accept edge to OutValid (99 on timeout)
    task automatic run_op(input logic sq, input logic [10:0] xe, input logic [10:0] ye,
                          input logic [52:0] xm, input logic [52:0] ym, output int lat);
        @(negedge clk);
        SqrtE = sq; XeE = xe; YeE = ye; XmE = xm; YmE = ym; InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; XeE = '1; YeE = '1; XmE = '1; YmE = '1; SqrtE = ~sq;
        lat = 0;
        while (!OutValid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!OutValid) lat = 99;
    endtask

    task automatic release_out();
        @(negedge clk);
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        nVec++;
        if (InReady !== 1'b1) begin
            nMis++; $display("FAIL release_inready got %b want 1", InReady);
        end
    endtask

    task automatic test_reset();
        #3;
        nVec++;
        if ({OutValid, Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn} !== '0) begin
            nMis++; $display("FAIL reset_outputs got %b %h %h %h %b %b want all 0",
                             OutValid, Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nVec++;
        if (InReady !== 1'b1) begin
            nMis++; $display("FAIL reset_inready got %b want 1", InReady);
        end
    endtask

    task automatic test_div_normal();
        int lat;
        run_op(1'b0, 11'd1023, 11'd1023, ONE, ONE, lat);
        nVec++;
        if (lat !== NORM_LAT) begin
            nMis++; $display("FAIL div_one_latency got %0d want %0d", lat, NORM_LAT);
        end
        nVec++;
        if ({Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn} !== {ONE, ONE, 13'd1023, 1'b0, 1'b0}) begin
            nMis++; $display("FAIL div_one_result got %h %h %h %b %b want %h %h 3ff 0 0",
                             Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn, ONE, ONE);
        end
        release_out();
    endtask

    task automatic test_div_subnormal();
        int lat;
        run_op(1'b0, 11'd0, 11'd1023, 53'd1, ONE, lat);
        nVec++;
        if (lat !== 2) begin
            nMis++; $display("FAIL div_sub_latency got %0d want 2", lat);
        end
        nVec++;
        if ({Xnorm, Dnorm, DivUe, ZeroIn} !== {ONE, ONE, 13'h1FCD, 1'b0}) begin
            nMis++; $display("FAIL div_sub_result got %h %h %h %b want %h %h 1fcd 0",
                             Xnorm, Dnorm, DivUe, ZeroIn, ONE, ONE);
        end
        release_out();
    endtask

    task automatic test_sqrt();
        logic [10:0] xe [3]  = '{11'd1025, 11'd1024, 11'd0};
        logic [52:0] xm [3]  = '{ONE, ONE, 53'd1};
        logic [12:0] eue [3] = '{13'd1024, 13'd1023, 13'd486};
        logic        eod [3] = '{1'b0, 1'b1, 1'b0};
        int          elt [3] = '{NORM_LAT, NORM_LAT, 2};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, xe[i], 11'd0, xm[i], 53'd0, lat);
            nVec++;
            if (lat !== elt[i]) begin
                nMis++; $display("FAIL sqrt%0d_latency got %0d want %0d", i, lat, elt[i]);
            end
            nVec++;
            if ({Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn} !== {ONE, 53'd0, eue[i], eod[i], 1'b0}) begin
                nMis++; $display("FAIL sqrt%0d_result got %h %h %h %b %b want %h 0 %h %b 0",
                                 i, Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn, ONE, eue[i], eod[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(1'b0, 11'd1024, 11'd1023, ONE, 53'd1 << 51, lat);
        for (int i = 0; i < 5; i++) begin
            nVec++;
            if ({OutValid, InReady, Xnorm, Dnorm, DivUe} !== {1'b1, 1'b0, ONE, ONE, 13'd1025}) begin
                nMis++; $display("FAIL hold%0d got %b %b %h %h %h want 1 0 %h %h 401",
                                 i, OutValid, InReady, Xnorm, Dnorm, DivUe, ONE, ONE);
            end
            @(posedge clk); #1;
        end
        release_out();
        nVec++;
        if (OutValid !== 1'b0) begin
            nMis++; $display("FAIL hold_release_outvalid got %b want 0", OutValid);
        end
    endtask

    task automatic test_abort_reset();
        int seen = 0;
        // Abort in IDLE with InValid must not start an operation
        @(negedge clk);
        Abort = 1'b1; InValid = 1'b1; XeE = 11'd1023; YeE = 11'd1023; XmE = ONE; YmE = ONE;
        @(posedge clk); #1;
        Abort = 1'b0; InValid = 1'b0;
        nVec++;
        if (InReady !== 1'b1) begin
            nMis++; $display("FAIL abort_idle_inready got %b want 1", InReady);
        end
        // Abort while in LZC
        @(negedge clk);
        XeE = 11'd0; XmE = 53'd3; InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0; Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        nVec++;
        if ({InReady, OutValid} !== 2'b10) begin
            nMis++; $display("FAIL abort_lzc got ready=%b valid=%b want 1 0", InReady, OutValid);
        end
        // Reset while in SHIFT; previous outputs are non-zero
        @(negedge clk);
        XeE = 11'd0; XmE = 53'd3; InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        nVec++;
        if ({OutValid, Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn} !== '0) begin
            nMis++; $display("FAIL reset_in_shift got %b %h %h %h %b %b want all 0",
                             OutValid, Xnorm, Dnorm, DivUe, SqrtOdd, ZeroIn);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (OutValid) seen++;
        end
        nVec++;
        if (seen !== 0 || InReady !== 1'b1) begin
            nMis++; $display("FAIL after_reset got valid_cycles=%0d ready=%b want 0 1", seen, InReady);
        end
    endtask

    task automatic test_zero();
        int lat;
        run_op(1'b0, 11'd1023, 11'd1023, 53'd0, ONE, lat);
        nVec++;
        if ({ZeroIn, Xnorm, Dnorm, DivUe, SqrtOdd} !== {1'b1, 53'd0, 53'd0, 13'd0, 1'b0}) begin
            nMis++; $display("FAIL div_zero got %b %h %h %h %b want 1 0 0 0 0",
                             ZeroIn, Xnorm, Dnorm, DivUe, SqrtOdd);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_div_normal();
        test_div_subnormal();
        test_sqrt();
        test_backpressure();
        test_zero();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
